// File: rtl/sram_ctrl.sv
// sram_ctrl: 64-bit line reads / 32-bit word writes over a 16-bit async SRAM bus.
// Optional SRAM_TURNAROUND_EN inserts one bus-turnaround cycle before DONE.
module sram_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [63:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
`ifdef SRAM_TURNAROUND_EN
  localparam logic [2:0] TURN  = 3'd4;
  localparam logic [2:0] POST  = TURN;
`else
  localparam logic [2:0] POST  = DONE;
`endif
  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [63:0] rd_q, rd_d;
  logic [18:0] off;
  logic [17:0] wbase, rbase;
  logic        last;
  logic        unused_ok;
  // only the low 19 offset bits reach the 18-bit halfword address
  assign off       = address[18:0] - BASE_ADDR[18:0];
  assign wbase     = {1'b0, off[17:2], 1'b0};
  assign rbase     = {off[18:3], 2'b00};
  assign unused_ok = ^{address[31:19], off[1:0]};
  assign last      = (state_q == READ && cnt_q == 2'd3) || (state_q == WRITE && cnt_q == 2'd1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: if (wr_en || rd_en) begin
        state_d = wr_en ? WRITE : READ;
        cnt_d   = 2'd0;
        addr_d  = wr_en ? wbase : rbase;
        wd_d    = write_data;
      end
      READ, WRITE: begin
        if (state_q == READ) rd_d[{cnt_q, 4'd0} +: 16] = SRAM_DQ;
        cnt_d   = cnt_q + 2'd1;
        state_d = last ? POST : state_q;
        addr_d  = last ? addr_q : addr_q + 18'd1;
      end
`ifdef SRAM_TURNAROUND_EN
      TURN: state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 18'd0;
      wd_q    <= 32'd0;
      rd_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
    end
  end
  assign read_data = rd_q;
  assign SRAM_ADDR = addr_q;
  assign ready     = (state_q == IDLE) ? ~(wr_en | rd_en) : (state_q == DONE);
  assign SRAM_WE_N = state_q != WRITE;
  assign SRAM_DQ   = (state_q == WRITE) ? (cnt_q[0] ? wd_q[31:16] : wd_q[15:0]) : 16'bz;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: per-cycle transaction model of sram_ctrl against a behavioural SRAM.
// A bench keeper value marks a released data bus; SRAM_TURNAROUND_EN adds the TURN cycle.
module tb_sram_ctrl;
`ifdef SRAM_TURNAROUND_EN
  localparam int TURN = 1;
`else
  localparam int TURN = 0;
`endif
  localparam logic [15:0] KEEP = 16'h5A3C;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = 32'd0, write_data = 32'd0;
  logic [63:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;
  logic        mem_oe = 1'b0, keep_en = 1'b1;
  logic [15:0] sram [0:262143];
  logic [15:0] model_mem [0:262143];
  logic [63:0] exp_line = 64'd0;
  int          n_chk = 0, n_fail = 0;
  typedef struct {
    bit          rdy;
    bit          we_n;
    bit          ca;
    logic [17:0] a;
    int          mode;
    logic [15:0] dq;
    bit          cl;
    logic [63:0] ln;
  } rec_t;
  rec_t q[$];
  rec_t cur;
  sram_ctrl #(.BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
  );
  always #5 clk = ~clk;
  assign SRAM_DQ = mem_oe ? sram[SRAM_ADDR] : (keep_en ? KEEP : 16'bz);
  always @(negedge clk) if (rst_n && !SRAM_WE_N && !SRAM_CE_N) sram[SRAM_ADDR] = SRAM_DQ;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // mode 0: bus released (keeper visible), 1: DUT drives dq, 2: SRAM drives
  function automatic rec_t mk(bit rdy, bit we_n, bit ca, logic [17:0] a, int mode,
                              logic [15:0] dq, bit cl, logic [63:0] ln);
    rec_t r;
    r.rdy = rdy; r.we_n = we_n; r.ca = ca; r.a = a; r.mode = mode;
    r.dq = (mode == 0) ? KEEP : dq; r.cl = cl; r.ln = ln;
    return r;
  endfunction
  always @(posedge clk) begin
    #2;
    mem_oe  = q.size() > 0 && q[0].mode == 2;
    keep_en = q.size() == 0 || q[0].mode == 0;
    #1;
    if (q.size() > 0) begin
      cur = q.pop_front();
      chk("ready", {63'd0, ready}, {63'd0, cur.rdy});
      chk("we_n", {63'd0, SRAM_WE_N}, {63'd0, cur.we_n});
      if (cur.ca) chk("addr", {46'd0, SRAM_ADDR}, {46'd0, cur.a});
      if (cur.mode != 2) chk("dq", {48'd0, SRAM_DQ}, {48'd0, cur.dq});
      if (cur.cl) chk("line", read_data, cur.ln);
    end
  end
  function automatic logic [17:0] base_of(bit w, logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return w ? {1'b0, off[17:2], 1'b0} : {off[18:3], 2'b00};
  endfunction
  task automatic run(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d, input bit mut);
    logic [17:0] b;
    logic [15:0] h;
    int n;
    @(posedge clk); #1;
    b = base_of(wr, a);
    n = wr ? 2 : 4;
    q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    for (int j = 0; j < n; j++) begin
      h = (j == 1) ? d[31:16] : d[15:0];
      q.push_back(mk(0, !wr, 1, b + 18'(j), wr ? 1 : 2, h, 0, 0));
      if (wr) model_mem[b + 18'(j)] = h;
    end
    if (TURN != 0) q.push_back(mk(0, 1, 1, b + 18'(n - 1), 0, 0, 0, 0));
    if (!wr) exp_line = {model_mem[b + 18'd3], model_mem[b + 18'd2], model_mem[b + 18'd1], model_mem[b]};
    q.push_back(mk(1, 1, 0, 0, 0, 0, 1, exp_line));
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    if (mut) begin
      @(posedge clk); #1;
      address = ~a; write_data = ~d;
      repeat (n + TURN) @(posedge clk);
    end else repeat (n + 1 + TURN) @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0;
  endtask
  task automatic abort(input bit wr, input logic [31:0] a, input logic [31:0] d, input int k);
    logic [17:0] b;
    logic [15:0] h;
    @(posedge clk); #1;
    b = base_of(wr, a);
    q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    for (int j = 0; j < k; j++) begin
      h = (j == 1) ? d[31:16] : d[15:0];
      q.push_back(mk(0, !wr, 1, b + 18'(j), wr ? 1 : 2, h, 0, 0));
      if (wr) model_mem[b + 18'(j)] = h;
    end
    wr_en = wr; rd_en = !wr; address = a; write_data = d;
    repeat (k) @(posedge clk);
    #7;
    mem_oe = 0; keep_en = 1;
    rst_n = 0; wr_en = 0; rd_en = 0;
    exp_line = 64'd0;
    #1;
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_line", read_data, 64'd0);
    chk("rst_we_n", {63'd0, SRAM_WE_N}, 64'd1);
    chk("rst_dq", {48'd0, SRAM_DQ}, {48'd0, KEEP});
    chk("rst_addr", {46'd0, SRAM_ADDR}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      sram[i] = 16'h1000 + 16'(i);
      model_mem[i] = 16'h1000 + 16'(i);
    end
    for (int i = 0; i < 4; i++) begin
      sram[18'h3FFFC + i] = 16'hA000 + 16'(i);
      model_mem[18'h3FFFC + i] = 16'hA000 + 16'(i);
    end
    #2;
    chk("init_ready", {63'd0, ready}, 64'd1);
    chk("init_we_n", {63'd0, SRAM_WE_N}, 64'd1);
    chk("init_dq", {48'd0, SRAM_DQ}, {48'd0, KEEP});
    chk("init_line", read_data, 64'd0);
    chk("init_addr", {46'd0, SRAM_ADDR}, 64'd0);
    chk("init_ctl", {60'd0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #3;
    chk("idle_ready", {63'd0, ready}, 64'd1);
    abort(0, 32'd1024, 32'd0, 2);
    run(1, 0, 32'd1024, 32'hDEADBEEF, 0);
    run(1, 0, 32'd1028, 32'h12345678, 0);
    run(0, 1, 32'd1024, 32'd0, 0);
    chk("line_1024", read_data, 64'h12345678_DEADBEEF);
    abort(1, 32'd1032, 32'h55AA55AA, 1);
    run(0, 1, 32'd1036, 32'd0, 0);
    chk("line_1036", read_data, 64'h1007_1006_1005_55AA);
    run(1, 1, 32'd1024, 32'hCAFEF00D, 0);
    chk("wr_keeps_line", read_data, 64'h1007_1006_1005_55AA);
    run(0, 1, 32'd1024, 32'd0, 0);
    chk("line_cafe", read_data[31:0], 64'hCAFEF00D);
    run(0, 1, 32'd1016, 32'd0, 0);
    chk("line_wrap", read_data, 64'hA003_A002_A001_A000);
    run(1, 0, 32'd1040, 32'h0BADF00D, 1);
    run(0, 1, 32'd1040, 32'd0, 1);
    chk("line_capture", read_data, 64'h100B_100A_0BAD_F00D);
    repeat (3) @(posedge clk);
    #4;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
